// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one fixed-latency memory between fetch and data ports
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_if_req,
    input  logic [WIDTH-1:0] i_if_addr,
    input  logic             i_if_flush,
    output logic             o_if_gnt,
    output logic             o_if_rvalid,
    output logic [WIDTH-1:0] o_if_rdata,
    input  logic             i_d_req,
    input  logic             i_d_we,
    input  logic [WIDTH-1:0] i_d_addr,
    input  logic [WIDTH-1:0] i_d_wdata,
    input  logic [3:0]       i_d_be,
    output logic             o_d_gnt,
    output logic             o_d_rvalid,
    output logic [WIDTH-1:0] o_d_rdata,
    output logic             o_mem_en,
    output logic             o_mem_we,
    output logic [WIDTH-1:0] o_mem_addr,
    output logic [WIDTH-1:0] o_mem_wdata,
    output logic [3:0]       o_mem_be,
    input  logic [WIDTH-1:0] i_mem_rdata,
    output logic             o_busy
);
    typedef enum logic {IDLE, WAIT} state_t;
    typedef enum logic {FETCH, DATA} owner_t;
    localparam logic [3:0] LAT = 4'(MEM_LATENCY);
    localparam logic [3:0] LIM = 4'(STARVE_LIMIT);
    state_t     r_state;
    owner_t     r_owner;
    logic       r_we;
    logic       r_flush;
    logic [3:0] r_cnt;
    logic [3:0] r_starve;
    logic       w_idle;
    logic       w_pick_if;
    logic       w_flush_now;
    assign w_idle      = r_state == IDLE;
    // fetch wins only when data is absent or fetch has been starved long enough
    assign w_pick_if   = i_if_req && (!i_d_req || r_starve == LIM);
    assign o_if_gnt    = w_idle && w_pick_if;
    assign o_d_gnt     = w_idle && i_d_req && !w_pick_if;
    assign o_mem_en    = o_if_gnt || o_d_gnt;
    assign o_mem_we    = o_d_gnt && i_d_we;
    assign o_mem_addr  = o_if_gnt ? i_if_addr : o_d_gnt ? i_d_addr : '0;
    assign o_mem_wdata = o_d_gnt ? i_d_wdata : '0;
    assign o_mem_be    = o_if_gnt ? 4'hF : o_d_gnt ? (i_d_we ? i_d_be : 4'hF) : 4'h0;
    assign o_busy      = !w_idle;
    // a flush only matters while a fetch is in flight or being granted right now
    assign w_flush_now = i_if_flush && ((!w_idle && r_owner == FETCH) || o_if_gnt);
    // issue/wait sequencing, starvation tracking and registered responses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= FETCH;
            r_we        <= 1'b0;
            r_flush     <= 1'b0;
            r_cnt       <= '0;
            r_starve    <= '0;
            o_if_rvalid <= 1'b0;
            o_if_rdata  <= '0;
            o_d_rvalid  <= 1'b0;
            o_d_rdata   <= '0;
        end else begin
            o_if_rvalid <= 1'b0;
            o_d_rvalid  <= 1'b0;
            if (w_flush_now) r_flush <= 1'b1;
            if (w_idle) begin
                r_starve <= (!i_if_req || o_if_gnt) ? 4'd0 :
                            (o_d_gnt && r_starve != LIM) ? r_starve + 4'd1 : r_starve;
                if (o_mem_en) begin
                    r_state <= WAIT;
                    r_owner <= o_if_gnt ? FETCH : DATA;
                    r_we    <= o_mem_we;
                    r_cnt   <= LAT;
                end
            end else begin
                r_cnt <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_state <= IDLE;
                    r_flush <= 1'b0;
                    if (r_owner == DATA) begin
                        o_d_rvalid <= 1'b1;
                        o_d_rdata  <= r_we ? '0 : i_mem_rdata;
                    end else if (!r_flush && !i_if_flush) begin
                        o_if_rvalid <= 1'b1;
                        o_if_rdata  <= i_mem_rdata;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vector table, starvation sequence and randomized model check
module tb_mem_port_arbiter;
    localparam int L  = 2;
    localparam int SL = 3;
    logic        clk, rst;
    logic        if_req, if_flush, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        d_req, d_we, d_gnt, d_rvalid;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic [3:0]  d_be, mem_be;
    logic        mem_en, mem_we, busy;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.WIDTH(32), .MEM_LATENCY(L), .STARVE_LIMIT(SL)) dut (
        .clk(clk), .rst(rst),
        .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
        .o_if_gnt(if_gnt), .o_if_rvalid(if_rvalid), .o_if_rdata(if_rdata),
        .i_d_req(d_req), .i_d_we(d_we), .i_d_addr(d_addr), .i_d_wdata(d_wdata), .i_d_be(d_be),
        .o_d_gnt(d_gnt), .o_d_rvalid(d_rvalid), .o_d_rdata(d_rdata),
        .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
        .o_mem_be(mem_be), .i_mem_rdata(mem_rdata), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic rst, ifr; logic [31:0] ia; logic fl, dr, dwe; logic [31:0] da, wd; logic [3:0] be; logic [31:0] mr;
        logic ig, dg, en, mwe; logic [31:0] ma, mwd; logic [3:0] mbe; logic bsy, irv; logic [31:0] ird; logic drv; logic [31:0] drd;
    } vec_t;
    vec_t vq[$];

    function automatic vec_t mk(
        input logic r, ifr, input logic [31:0] ia, input logic fl, dr, dwe, input logic [31:0] da, wd,
        input logic [3:0] be, input logic [31:0] mr,
        input logic ig, dg, en, mwe, input logic [31:0] ma, mwd, input logic [3:0] mbe,
        input logic bsy, irv, input logic [31:0] ird, input logic drv, input logic [31:0] drd);
        return '{r, ifr, ia, fl, dr, dwe, da, wd, be, mr, ig, dg, en, mwe, ma, mwd, mbe, bsy, irv, ird, drv, drd};
    endfunction

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", n, a, e);
        end
    endtask

    task automatic chk_all(input string p, input logic ig, dg, en, mwe, input logic [31:0] ma, mwd,
                           input logic [3:0] mbe, input logic bsy, irv, input logic [31:0] ird,
                           input logic drv, input logic [31:0] drd);
        chk({p, ".if_gnt"}, 32'(if_gnt), 32'(ig));
        chk({p, ".d_gnt"}, 32'(d_gnt), 32'(dg));
        chk({p, ".mem_en"}, 32'(mem_en), 32'(en));
        chk({p, ".mem_we"}, 32'(mem_we), 32'(mwe));
        chk({p, ".mem_addr"}, mem_addr, ma);
        chk({p, ".mem_wdata"}, mem_wdata, mwd);
        chk({p, ".mem_be"}, 32'(mem_be), 32'(mbe));
        chk({p, ".busy"}, 32'(busy), 32'(bsy));
        chk({p, ".if_rvalid"}, 32'(if_rvalid), 32'(irv));
        chk({p, ".if_rdata"}, if_rdata, ird);
        chk({p, ".d_rvalid"}, 32'(d_rvalid), 32'(drv));
        chk({p, ".d_rdata"}, d_rdata, drd);
    endtask

    // reference model state, expressed in absolute cycle numbers
    int t, free_t, cap_t, starve;
    bit pend, own_d, own_we, flushed, e_irv, e_drv, n_irv, n_drv, drop_if, drop_d;
    logic [31:0] e_ird, e_drd;

    initial begin
        logic [31:0] I1, I2, D1, D3;
        logic idle, e_ig, e_dg;
        I1 = 32'h00500093; I2 = 32'hAAAA5555; D1 = 32'h11112222; D3 = 32'h0F0F0F0F;
        // reset state
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      0,0,0,0,0));
        // single fetch, latency 2
        vq.push_back(mk(0,1,'h100,0,0,0,0,0,0,0,        1,0,1,0,'h100,0,'hF, 0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      1,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,I1,           0,0,0,0,0,0,0,      1,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      0,1,I1,0,0));
        // simultaneous fetch and load: data first
        vq.push_back(mk(0,1,'h200,0,1,0,'h2000,0,0,0,   0,1,1,0,'h2000,0,'hF,0,0,I1,0,0));
        vq.push_back(mk(0,1,'h200,0,0,0,0,0,0,0,        0,0,0,0,0,0,0,      1,0,I1,0,0));
        vq.push_back(mk(0,1,'h200,0,0,0,0,0,0,D1,       0,0,0,0,0,0,0,      1,0,I1,0,0));
        vq.push_back(mk(0,1,'h200,0,0,0,0,0,0,0,        1,0,1,0,'h200,0,'hF, 0,0,I1,1,D1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      1,0,I1,0,D1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,I2,           0,0,0,0,0,0,0,      1,0,I1,0,D1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      0,1,I2,0,D1));
        // store ack
        vq.push_back(mk(0,0,0,0,1,1,'h40,'hDEADBEEF,'h3,0, 0,1,1,1,'h40,'hDEADBEEF,'h3,0,0,I2,0,D1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      1,0,I2,0,D1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,'h12345678,   0,0,0,0,0,0,0,      1,0,I2,0,D1));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      0,0,I2,1,0));
        // flushed fetch, pending load granted at cycle 3
        vq.push_back(mk(0,1,'h300,0,0,0,0,0,0,0,        1,0,1,0,'h300,0,'hF, 0,0,I2,0,0));
        vq.push_back(mk(0,0,0,1,1,0,'h44,0,0,0,         0,0,0,0,0,0,0,      1,0,I2,0,0));
        vq.push_back(mk(0,0,0,0,1,0,'h44,0,0,'hBADBAD00,0,0,0,0,0,0,0,      1,0,I2,0,0));
        vq.push_back(mk(0,0,0,0,1,0,'h44,0,0,0,         0,1,1,0,'h44,0,'hF, 0,0,I2,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      1,0,I2,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,D3,           0,0,0,0,0,0,0,      1,0,I2,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      0,0,I2,1,D3));
        // reset during an in-flight fetch
        vq.push_back(mk(0,1,'h500,0,0,0,0,0,0,0,        1,0,1,0,'h500,0,'hF, 0,0,I2,0,D3));
        vq.push_back(mk(1,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      1,0,I2,0,D3));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,'hFFFFFFFF,   0,0,0,0,0,0,0,      0,0,0,0,0));
        vq.push_back(mk(0,1,'h600,0,0,0,0,0,0,0,        1,0,1,0,'h600,0,'hF, 0,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      1,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,'hCAFEF00D,   0,0,0,0,0,0,0,      1,0,0,0,0));
        vq.push_back(mk(0,0,0,0,0,0,0,0,0,0,            0,0,0,0,0,0,0,      0,1,'hCAFEF00D,0,0));

        rst = 1; if_req = 0; if_addr = 0; if_flush = 0; d_req = 0; d_we = 0;
        d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < vq.size(); i++) begin
            if (i != 0) @(negedge clk);
            rst = vq[i].rst; if_req = vq[i].ifr; if_addr = vq[i].ia; if_flush = vq[i].fl;
            d_req = vq[i].dr; d_we = vq[i].dwe; d_addr = vq[i].da; d_wdata = vq[i].wd;
            d_be = vq[i].be; mem_rdata = vq[i].mr;
            #1;
            chk_all($sformatf("v%0d", i), vq[i].ig, vq[i].dg, vq[i].en, vq[i].mwe, vq[i].ma, vq[i].mwd,
                    vq[i].mbe, vq[i].bsy, vq[i].irv, vq[i].ird, vq[i].drv, vq[i].drd);
        end

        // both ports requesting continuously: fetch forced in after SL data grants
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            rst = 0; if_req = 1; if_addr = 32'h800 + 32'(k); d_req = 1; d_we = 0;
            d_addr = 32'h4000 + 32'(k); d_wdata = 0; if_flush = 0; mem_rdata = $urandom;
            #1;
            chk($sformatf("starve%0d.if_gnt", k), 32'(if_gnt), 32'(k == 9));
            chk($sformatf("starve%0d.d_gnt", k), 32'(d_gnt), 32'(k % 3 == 0 && k != 9));
        end

        // randomized run against the cycle-level reference model
        @(negedge clk);
        rst = 1; if_req = 0; d_req = 0; if_flush = 0;
        t = 0; free_t = 0; cap_t = -1; starve = 0; pend = 0; own_d = 0; own_we = 0; flushed = 0;
        e_irv = 0; e_drv = 0; e_ird = 0; e_drd = 0; drop_if = 0; drop_d = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (drop_if) if_req = 0;
            if (drop_d) d_req = 0;
            if (!if_req && $urandom_range(0, 9) < 4) begin
                if_req = 1; if_addr = $urandom;
            end
            if (!d_req && $urandom_range(0, 9) < 4) begin
                d_req = 1; d_we = 1'($urandom); d_addr = $urandom; d_wdata = $urandom; d_be = 4'($urandom);
            end
            if_flush = $urandom_range(0, 7) == 0;
            rst = $urandom_range(0, 63) == 0;
            mem_rdata = $urandom;
            #1;
            idle = t >= free_t;
            e_ig = idle && if_req && (!d_req || starve == SL);
            e_dg = idle && d_req && !e_ig;
            chk_all($sformatf("rnd%0d", c), e_ig, e_dg, e_ig | e_dg, e_dg & d_we,
                    e_ig ? if_addr : e_dg ? d_addr : 32'h0, e_dg ? d_wdata : 32'h0,
                    e_ig ? 4'hF : e_dg ? (d_we ? d_be : 4'hF) : 4'h0, !idle, e_irv, e_ird, e_drv, e_drd);
            drop_if = e_ig; drop_d = e_dg;
            if (rst) begin
                free_t = t + 1; starve = 0; pend = 0;
                e_irv = 0; e_drv = 0; e_ird = 0; e_drd = 0;
            end else begin
                n_irv = 0; n_drv = 0;
                if (pend && !own_d && if_flush) flushed = 1;
                if (pend && t == cap_t) begin
                    pend = 0;
                    if (own_d) begin
                        n_drv = 1; e_drd = own_we ? 32'h0 : mem_rdata;
                    end else if (!flushed) begin
                        n_irv = 1; e_ird = mem_rdata;
                    end
                end
                if (idle) starve = (!if_req || e_ig) ? 0 : (e_dg && starve < SL) ? starve + 1 : starve;
                if (e_ig || e_dg) begin
                    pend = 1; own_d = e_dg; own_we = e_dg & d_we; flushed = e_ig & if_flush;
                    cap_t = t + L; free_t = t + L + 1;
                end
                e_irv = n_irv; e_drv = n_drv;
            end
            t++;
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
